// File: rtl/char_pwm_array_gen.sv
// Multi-pixel character PWM generator: NUM_PIXELS PWM lines driven from a run-time-writable pattern table.
// Optional macro CHAR_PWM_PHASE_STAGGER_EN offsets each pixel's compare phase to spread rising edges.
module char_pwm_array_gen #(
  parameter int NUM_CHARS  = 4,
  parameter int NUM_PIXELS = 9,
  parameter int DUTY_W     = 8,
  parameter int FRAME_W    = 8,
  parameter int CHAR_W     = 2,
  parameter int PIX_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [CHAR_W-1:0]     wr_char,
  input  logic [PIX_W-1:0]      wr_pixel,
  input  logic [DUTY_W-1:0]     wr_duty,
  input  logic [CHAR_W-1:0]     char_select,
  input  logic [FRAME_W-1:0]    frames,
  input  logic                  start,
  input  logic                  stop,
  output logic [NUM_PIXELS-1:0] pwm_out,
  output logic [CHAR_W-1:0]     active_char,
  output logic                  period_tick,
  output logic                  busy,
  output logic                  done
);

  localparam logic [DUTY_W-1:0]  CNT_ZERO = {DUTY_W{1'b0}};
  localparam logic [DUTY_W-1:0]  CNT_ONE  = {{(DUTY_W-1){1'b0}}, 1'b1};
  localparam logic [DUTY_W-1:0]  CNT_MAX  = {DUTY_W{1'b1}};
  localparam logic [FRAME_W-1:0] FR_ZERO  = {FRAME_W{1'b0}};
  localparam logic [FRAME_W-1:0] FR_ONE   = {{(FRAME_W-1){1'b0}}, 1'b1};
`ifdef CHAR_PWM_PHASE_STAGGER_EN
  localparam int STAGGER_STEP = (1 << DUTY_W) / NUM_PIXELS;
`endif

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_r;
  logic [DUTY_W-1:0]  table_r       [NUM_CHARS][NUM_PIXELS];
  logic [DUTY_W-1:0]  shadow_r      [NUM_PIXELS];
  logic [DUTY_W-1:0]  shadow_next_s [NUM_PIXELS];
  logic [NUM_PIXELS-1:0] cmp_s;
  logic [DUTY_W-1:0]  cnt_r;
  logic [FRAME_W-1:0] frames_left_r;

  // Pattern table write port; indices with no matching entry fall through the loops and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CHARS; c++) begin
        for (int p = 0; p < NUM_PIXELS; p++) begin
          table_r[c][p] <= {DUTY_W{1'b0}};
        end
      end
    end else if (wr_en) begin
      for (int c = 0; c < NUM_CHARS; c++) begin
        for (int p = 0; p < NUM_PIXELS; p++) begin
          if (wr_char == CHAR_W'(c) && wr_pixel == PIX_W'(p)) begin
            table_r[c][p] <= wr_duty;
          end
        end
      end
    end
  end

  // Row of the table selected by char_select; launch and wrap both load the shadow from it.
  always_comb begin
    for (int p = 0; p < NUM_PIXELS; p++) begin
      shadow_next_s[p] = {DUTY_W{1'b0}};
    end
    for (int c = 0; c < NUM_CHARS; c++) begin
      for (int p = 0; p < NUM_PIXELS; p++) begin
        shadow_next_s[p] = (char_select == CHAR_W'(c)) ? table_r[c][p] : shadow_next_s[p];
      end
    end
  end

  // Per-pixel duty compare against the (optionally phase-shifted) period counter.
  always_comb begin
    logic [DUTY_W-1:0] phase_s;
    phase_s = cnt_r;
    for (int p = 0; p < NUM_PIXELS; p++) begin
`ifdef CHAR_PWM_PHASE_STAGGER_EN
      phase_s = cnt_r + DUTY_W'(p * STAGGER_STEP);
`else
      phase_s = cnt_r;
`endif
      cmp_s[p] = (phase_s < shadow_r[p]);
    end
  end

  // Control FSM with registered outputs; stop wins over wrap and completion in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      cnt_r         <= CNT_ZERO;
      frames_left_r <= FR_ZERO;
      active_char   <= {CHAR_W{1'b0}};
      pwm_out       <= {NUM_PIXELS{1'b0}};
      period_tick   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      for (int p = 0; p < NUM_PIXELS; p++) begin
        shadow_r[p] <= {DUTY_W{1'b0}};
      end
    end else begin
      period_tick <= 1'b0;
      done        <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          pwm_out <= {NUM_PIXELS{1'b0}};
          if (start && !stop) begin
            active_char   <= char_select;
            frames_left_r <= frames;
            cnt_r         <= CNT_ZERO;
            shadow_r      <= shadow_next_s;
            busy          <= 1'b1;
            state_r       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            pwm_out <= {NUM_PIXELS{1'b0}};
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            pwm_out <= cmp_s;
            cnt_r   <= cnt_r + CNT_ONE;
            if (cnt_r == CNT_MAX) begin
              period_tick <= 1'b1;
              if (frames_left_r == FR_ONE) begin
                busy    <= 1'b0;
                done    <= 1'b1;
                state_r <= ST_IDLE;
              end else begin
                // frames_left of zero means continuous mode and is never decremented
                if (frames_left_r != FR_ZERO) begin
                  frames_left_r <= frames_left_r - FR_ONE;
                end
                active_char <= char_select;
                shadow_r    <= shadow_next_s;
              end
            end
          end
        end
        default: begin
          pwm_out <= {NUM_PIXELS{1'b0}};
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_pwm_array_gen.sv
// Directed scoreboard bench for char_pwm_array_gen (DUTY_W=4, NUM_PIXELS=9): per-window pulse counts.
module tb_char_pwm_array_gen;
  localparam int NP = 9;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_char = 2'd0;
  logic [3:0]    wr_pixel = 4'd0;
  logic [DW-1:0] wr_duty = 4'd0;
  logic [1:0]    char_select = 2'd0;
  logic [7:0]    frames = 8'd0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [NP-1:0] pwm_out;
  logic [1:0]    active_char;
  logic          period_tick;
  logic          busy;
  logic          done;

  char_pwm_array_gen #(.NUM_CHARS(4), .NUM_PIXELS(NP), .DUTY_W(DW), .FRAME_W(8), .CHAR_W(2), .PIX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_char(wr_char), .wr_pixel(wr_pixel),
    .wr_duty(wr_duty), .char_select(char_select), .frames(frames), .start(start), .stop(stop),
    .pwm_out(pwm_out), .active_char(active_char), .period_tick(period_tick), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]            id;
    logic [NP-1:0][7:0]    high;
    logic [7:0]            ticks;
    logic [7:0]            dones;
    logic                  busy_end;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   win_id = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected window result: only pixels 0 and 8 carry non-zero duties in every test.
  task automatic push_exp(input int h0, input int h8, input int t, input int d, input logic b);
    exp_t e;
    e = '0;
    e.id = 8'(win_id);
    win_id++;
    e.high[0] = 8'(h0);
    e.high[NP-1] = 8'(h8);
    e.ticks = 8'(t);
    e.dones = 8'(d);
    e.busy_end = b;
    sb.push_back(e);
  endtask

  task automatic measure(input int n);
    exp_t e;
    exp_t m;
    e = sb.pop_front();
    m = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      wr_en = 1'b0;
      for (int p = 0; p < NP; p++) begin
        if (pwm_out[p]) m.high[p] = m.high[p] + 8'd1;
      end
      if (period_tick) m.ticks = m.ticks + 8'd1;
      if (done) m.dones = m.dones + 8'd1;
      m.busy_end = busy;
    end
    check($sformatf("w%0d_high", e.id), 128'(m.high), 128'(e.high));
    check($sformatf("w%0d_ticks", e.id), 128'(m.ticks), 128'(e.ticks));
    check($sformatf("w%0d_done", e.id), 128'(m.dones), 128'(e.dones));
    check($sformatf("w%0d_busy", e.id), 128'(m.busy_end), 128'(e.busy_end));
  endtask

  task automatic write_tbl(input logic [1:0] c, input logic [3:0] p, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_char = c; wr_pixel = p; wr_duty = d;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic launch(input logic [1:0] ch, input logic [7:0] fr);
    char_select = ch; frames = fr; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_pwm", 128'(pwm_out), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_tick", 128'(period_tick), 128'(0));
    check("rst_char", 128'(active_char), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Basic duty, single frame
    write_tbl(2'd1, 4'd0, 4'd4);
    write_tbl(2'd1, 4'd8, 4'd15);
    write_tbl(2'd3, 4'd9, 4'd7);
    launch(2'd1, 8'd1);
    check("launch_busy", 128'(busy), 128'(1));
    check("launch_char", 128'(active_char), 128'(1));
    push_exp(4, 15, 1, 1, 1'b0);
    measure(16);
    push_exp(0, 0, 0, 0, 1'b0);
    measure(4);

    // Three frames
    launch(2'd1, 8'd3);
    push_exp(4, 15, 1, 0, 1'b1); measure(16);
    push_exp(4, 15, 1, 0, 1'b1); measure(16);
    push_exp(4, 15, 1, 1, 1'b0); measure(16);
    push_exp(0, 0, 0, 0, 1'b0); measure(5);

    // Character switch in continuous mode
    write_tbl(2'd2, 4'd0, 4'd8);
    launch(2'd1, 8'd0);
    push_exp(4, 5, 0, 0, 1'b1); measure(5);
    char_select = 2'd2;
    push_exp(0, 10, 1, 0, 1'b1); measure(11);
    check("switch_char", 128'(active_char), 128'(2));
    push_exp(8, 0, 1, 0, 1'b1); measure(16);

    // Table write to the running character mid-period
    char_select = 2'd1;
    push_exp(8, 0, 1, 0, 1'b1); measure(16);
    check("back_char", 128'(active_char), 128'(1));
    push_exp(3, 3, 0, 0, 1'b1); measure(3);
    wr_en = 1'b1; wr_char = 2'd1; wr_pixel = 4'd0; wr_duty = 4'd10;
    push_exp(1, 12, 1, 0, 1'b1); measure(13);
    push_exp(10, 15, 1, 0, 1'b1); measure(16);

    // Abort at cnt=7
    push_exp(7, 7, 0, 0, 1'b1); measure(7);
    stop = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("stop_busy", 128'(busy), 128'(0));
    check("stop_done", 128'(done), 128'(0));
    check("stop_tick", 128'(period_tick), 128'(0));
    stop = 1'b0;
    push_exp(0, 0, 0, 0, 1'b0); measure(4);

    // start together with stop stays idle
    start = 1'b1; stop = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("startstop_busy", 128'(busy), 128'(0));
    start = 1'b0; stop = 1'b0;

    // start while running is ignored
    launch(2'd1, 8'd1);
    push_exp(5, 5, 0, 0, 1'b1); measure(5);
    start = 1'b1; char_select = 2'd2; frames = 8'd5;
    push_exp(5, 5, 0, 0, 1'b1); measure(5);
    check("restart_char", 128'(active_char), 128'(1));
    start = 1'b0;
    push_exp(0, 5, 1, 1, 1'b0); measure(6);
    push_exp(0, 0, 0, 0, 1'b0); measure(3);

    // Reset mid-run clears outputs and table
    launch(2'd1, 8'd0);
    push_exp(9, 9, 0, 0, 1'b1); measure(9);
    rst_n = 1'b0;
    #1;
    check("mrst_pwm", 128'(pwm_out), 128'(0));
    check("mrst_busy", 128'(busy), 128'(0));
    check("mrst_char", 128'(active_char), 128'(0));
    check("mrst_tick", 128'(period_tick), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch(2'd1, 8'd1);
    push_exp(0, 0, 1, 1, 1'b0); measure(16);
    check("sb_empty", 128'(sb.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/char_pwm_array_gen.md
Name: char_pwm_array_gen

Overview:
- Parametrised successor to the single-output character PWM generator.
- Drives NUM_PIXELS parallel PWM pixel lines encoding one of NUM_CHARS run-time-writable character patterns into the neuromorphic input array.
- Adds a per-pixel duty table, glitch-free character switching at period boundaries, and a start/stop/done frame-count handshake.

Parameters:
- NUM_CHARS, 4: number of stored character patterns.
- NUM_PIXELS, 9: pixel outputs; 3x3 character grid.
- DUTY_W, 8: duty/counter width; period = 2^DUTY_W cycles.
- FRAME_W, 8: width of frame-count input.
- CHAR_W, 2: char select width; must satisfy 2^CHAR_W >= NUM_CHARS.
- PIX_W, 4: pixel index width; must satisfy 2^PIX_W >= NUM_PIXELS.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  pattern-table write strobe.
- wr_char  in  CHAR_W  character index of write.
- wr_pixel  in  PIX_W  pixel index of write.
- wr_duty  in  DUTY_W  duty value written.
- char_select  in  CHAR_W  requested character.
- frames  in  FRAME_W  number of periods to run; 0 = continuous.
- start  in  1  launch request; level-sampled.
- stop  in  1  abort request.
- pwm_out  out  NUM_PIXELS  pixel PWM lines.
- active_char  out  CHAR_W  character currently driven.
- period_tick  out  1  one-cycle pulse on last cycle of each period.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (async, rst_n=0):
  - Table entries, shadow duties, counter, frames_left, active_char all 0.
  - pwm_out, period_tick, busy, done all 0. State IDLE.
- Table write:
  - wr_en=1 writes table[wr_char][wr_pixel] <= wr_duty at the edge, in any state.
  - Out-of-range indices are ignored.
- Shadow duties:
  - NUM_PIXELS registers, loaded from table[char] at launch and at every period wrap.
  - Writes to the running character take effect only from the next period.
- States: IDLE, RUN.
- IDLE:
  - pwm_out forced 0 at each edge.
  - When start=1 and stop=0: active_char <= char_select, frames_left <= frames, cnt <= 0, load shadow, busy <= 1, go RUN.
- RUN, counter:
  - cnt increments each cycle and wraps at 2^DUTY_W-1.
- RUN, output compare:
  - pwm_out[p] <= (cnt < shadow[p]), registered, so pwm_out lags cnt by one cycle.
  - First compare result appears 1 cycle after launch edge.
  - duty 0: never high. Duty max: high 2^DUTY_W-1 of 2^DUTY_W cycles.
- RUN, cnt==max:
  - period_tick <= 1.
  - If frames_left==1: go IDLE, busy <= 0, done <= 1 for one cycle.
  - Else: decrement frames_left (not when frames==0 continuous mode), sample char_select into active_char, reload shadow.
- stop=1 in RUN:
  - Go IDLE at that edge, busy <= 0, no done, no period_tick.
  - pwm_out is 0 from the next edge.
  - stop has priority over wrap/completion in the same cycle.
- start while RUN: ignored. start with stop in IDLE: stays IDLE.
- char_select changes mid-period: ignored until next wrap; pwm_out never glitches mid-period.
- Reset mid-RUN: immediate return to reset values. Table contents are lost.

Optional Feature:
- Macro: CHAR_PWM_PHASE_STAGGER_EN.
- Defined: pixel p compares ((cnt + p*(2^DUTY_W/NUM_PIXELS)) mod 2^DUTY_W) < shadow[p]. This spreads rising edges to limit simultaneous switching. Duty ratio per pixel is unchanged; period_tick and shadow reload still occur at cnt==max.
- Undefined: all pixels compare against the raw cnt, so rising edges align at period start.

Test Plan:
- Sim params DUTY_W=4, NUM_PIXELS=9.
- Basic duty: write table[1][0]=4, [1][8]=15, others 0; char_select=1, frames=1, start.
  -> pwm_out[0] high 4 cycles, pwm_out[8] high 15 cycles, other pixels 0.
  -> period_tick and done one cycle each after 16 cycles; busy falls with done.
- Frame count: frames=3.
  -> exactly 3 period_tick pulses 16 cycles apart; one done; pwm_out 0 afterwards.
- Character switch: run char 1, continuous; change char_select to 2 (table[2][0]=8) at cnt=5.
  -> current period unchanged; next period pwm_out[0] high 8 cycles; active_char=2 after wrap.
- Write while running: table[1][0] changed 4->10 mid-period.
  -> current period width 4, next period width 10.
- Abort and handshake: stop at cnt=7.
  -> busy 0 next edge, no done, pwm_out 0.
  -> start with stop asserted together stays IDLE; start while busy ignored.
- Reset mid-run: rst_n low at cnt=9.
  -> all outputs 0 immediately; table reads 0 (pwm_out stays 0 after relaunch).
  -> With CHAR_PWM_PHASE_STAGGER_EN defined, pixel rising edges are offset, per-pixel high counts unchanged.
